// File: rtl/mux_matrix_pkg.sv
// Shared types and defaults for the matrix mux scan controller.
// Holds the scan FSM state enum, default parameters and index-width helper.
package mux_matrix_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CONV,
    WAIT,
    NEXT,
    DONE
  } state_e;

  localparam int unsigned DefRows    = 2;
  localparam int unsigned DefCols    = 2;
  localparam int unsigned DefWidth   = 5;
  localparam int unsigned DefSettle  = 4;
  localparam int unsigned DefTimeout = 255;

  // Counter width for n distinct values, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column wrap counter pair with terminal flags.
// Ports: clk_i, rst_ni, clr_i, en_i -> row_o, col_o, col_last_o, row_last_o.
module matrix_index_counter
  import mux_matrix_pkg::*;
#(
  parameter int unsigned Rows = DefRows,
  parameter int unsigned Cols = DefCols
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       en_i,
  output logic [idx_w(Rows)-1:0]     row_o,
  output logic [idx_w(Cols)-1:0]     col_o,
  output logic                       col_last_o,
  output logic                       row_last_o
);

  localparam int unsigned RW = idx_w(Rows);
  localparam int unsigned CW = idx_w(Cols);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;

  assign col_last_o = (r_col == CW'(Cols - 1));
  assign row_last_o = (r_row == RW'(Rows - 1));
  assign row_o      = r_row;
  assign col_o      = r_col;

  // Column is the fast index; the last pixel wraps both to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_row <= '0;
      r_col <= '0;
    end else if (clr_i) begin
      r_row <= '0;
      r_col <= '0;
    end else if (en_i) begin
      if (col_last_o) begin
        r_col <= '0;
        r_row <= row_last_o ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_matrix_scan_ctrl.sv
// Full-frame scan controller: settle mux, start ADC, await done, step pixel.
// In: clk_i rst_ni start_i abort_i adc_done_i; out: indices, strobes, flags.
module mux_matrix_scan_ctrl
  import mux_matrix_pkg::*;
#(
  parameter int unsigned Rows          = DefRows,
  parameter int unsigned Cols          = DefCols,
  parameter int unsigned Width         = DefWidth,
  parameter int unsigned SettleCycles  = DefSettle,
  parameter int unsigned TimeoutCycles = DefTimeout
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             adc_done_i,
  output logic [Width-1:0] row_o,
  output logic [Width-1:0] col_o,
  output logic             mux_en_o,
  output logic             adc_start_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             err_o
);

  localparam int unsigned RW = idx_w(Rows);
  localparam int unsigned CW = idx_w(Cols);
  localparam int unsigned SW = idx_w(SettleCycles);
  localparam int unsigned TW = idx_w(TimeoutCycles);

  if (Width < RW || Width < CW) begin : g_width_err
    $error("Width too small for matrix index");
  end

  state_e        r_state;
  logic [SW-1:0] r_settle;
  logic [TW-1:0] r_tmo;
  logic          r_mux_en;
  logic          r_adc_start;
  logic          r_busy;
  logic          r_frame_done;
  logic          r_err;

  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_abort;
  logic          w_tmo;
  logic          w_idx_clr;
  logic          w_idx_en;

  assign w_abort = (r_state != IDLE) && abort_i;
  assign w_tmo   = (r_state == WAIT) && !adc_done_i &&
                   (r_tmo == TW'(TimeoutCycles - 1));

  // Indices return to (0,0) on frame start, abort and timeout.
  assign w_idx_clr = w_abort || w_tmo ||
                     ((r_state == IDLE) && start_i);
  assign w_idx_en  = (r_state == NEXT);

  matrix_index_counter #(
    .Rows (Rows),
    .Cols (Cols)
  ) u_idx (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (w_idx_clr),
    .en_i       (w_idx_en),
    .row_o      (w_row),
    .col_o      (w_col),
    .col_last_o (w_col_last),
    .row_last_o (w_row_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_settle     <= '0;
      r_tmo        <= '0;
      r_mux_en     <= 1'b0;
      r_adc_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_adc_start  <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_abort) begin
        r_state  <= IDLE;
        r_mux_en <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (start_i) begin
              r_state  <= SETTLE;
              r_settle <= SW'(SettleCycles - 1);
              r_err    <= 1'b0;
              r_mux_en <= 1'b1;
              r_busy   <= 1'b1;
            end
          end
          SETTLE: begin
            if (r_settle == '0) begin
              r_state     <= CONV;
              r_adc_start <= 1'b1;
            end else begin
              r_settle <= r_settle - 1'b1;
            end
          end
          CONV: begin
            r_state <= WAIT;
            r_tmo   <= '0;
          end
          WAIT: begin
            if (adc_done_i) begin
              r_state  <= NEXT;
              r_mux_en <= 1'b0;
            end else if (w_tmo) begin
              r_state  <= IDLE;
              r_err    <= 1'b1;
              r_mux_en <= 1'b0;
              r_busy   <= 1'b0;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          NEXT: begin
            if (w_col_last && w_row_last) begin
              r_state      <= DONE;
              r_frame_done <= 1'b1;
            end else begin
              r_state  <= SETTLE;
              r_settle <= SW'(SettleCycles - 1);
              r_mux_en <= 1'b1;
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state  <= IDLE;
            r_mux_en <= 1'b0;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign row_o        = Width'(w_row);
  assign col_o        = Width'(w_col);
  assign mux_en_o     = r_mux_en;
  assign adc_start_o  = r_adc_start;
  assign busy_o       = r_busy;
  assign frame_done_o = r_frame_done;
  assign err_o        = r_err;

endmodule

// File: doc/mux_matrix_scan_ctrl.md
MUX_MATRIX_SCAN_CTRL -- requirements
Module: mux_matrix_scan_ctrl

Interface
REQ-001 The block SHALL have parameter Rows, default 2, meaning number of matrix rows (>=1).
REQ-002 The block SHALL have parameter Cols, default 2, meaning number of matrix columns (>=1).
REQ-003 The block SHALL have parameter Width, default 5, meaning bit width of row/column index outputs.
REQ-004 The block SHALL have parameter SettleCycles, default 4, meaning mux settling clocks per pixel (>=1).
REQ-005 The block SHALL have parameter TimeoutCycles, default 255, meaning max clocks waiting for ADC done (>=1).
REQ-006 clk_i  input  1  single clock; all logic on rising edge.
REQ-007 rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 start_i  input  1  request one full-frame scan; honoured only in IDLE.
REQ-009 abort_i  input  1  synchronous abort of the scan in progress.
REQ-010 adc_done_i  input  1  ADC conversion-complete strobe.
REQ-011 row_o  output  Width  current row index, zero-extended.
REQ-012 col_o  output  Width  current column index, zero-extended.
REQ-013 mux_en_o  output  1  matrix multiplexer enable.
REQ-014 adc_start_o  output  1  one-cycle ADC conversion start pulse.
REQ-015 busy_o  output  1  high in every state except IDLE.
REQ-016 frame_done_o  output  1  one-cycle pulse at frame completion.
REQ-017 err_o  output  1  sticky ADC timeout flag.

Function
REQ-018 The FSM SHALL have states IDLE, SETTLE, CONV, WAIT, NEXT, DONE.
REQ-019 IDLE: start_i=1 SHALL go to SETTLE with row=col=0, clear err_o, and load the settle counter.
REQ-020 SETTLE SHALL last exactly SettleCycles clocks, then go to CONV.
REQ-021 CONV SHALL last one clock with adc_start_o=1, then go to WAIT with the timeout counter cleared.
REQ-022 WAIT: adc_done_i=1 SHALL go to NEXT; adc_done_i in SETTLE/CONV/NEXT/DONE/IDLE SHALL be ignored.
REQ-023 WAIT: TimeoutCycles clocks without adc_done_i SHALL set err_o and go to IDLE with no frame_done_o.
REQ-024 NEXT, col<Cols-1: col+1, go to SETTLE.
REQ-025 NEXT, col=Cols-1 and row<Rows-1: col=0, row+1, go to SETTLE.
REQ-026 NEXT, col=Cols-1 and row=Rows-1: go to DONE.
REQ-027 DONE SHALL pulse frame_done_o for one clock, then go to IDLE with row=col=0.
REQ-028 mux_en_o SHALL be 1 in SETTLE, CONV and WAIT, and 0 otherwise.
REQ-029 row_o/col_o SHALL be stable from SETTLE entry through NEXT for each pixel.
REQ-030 abort_i=1 in any non-IDLE state SHALL go to IDLE next clock, with row=col=0, all strobes 0, and err_o unchanged; abort_i SHALL take priority over adc_done_i and timeout.
REQ-031 start_i while busy_o=1 SHALL be ignored, with no queuing.
REQ-032 Row/column counters SHALL be ceil(log2) wide internally and zero-extended to Width; Width smaller than the needed index width is a parameter error.
REQ-033 Per-pixel latency SHALL be SettleCycles+1+N+1 clocks, where N is the WAIT clocks including the done cycle.

Reset
REQ-034 rst_ni=0 SHALL asynchronously force IDLE, row_o=col_o=0, mux_en_o=0, adc_start_o=0, busy_o=0, frame_done_o=0, err_o=0, and all counters 0.
REQ-035 Reset release SHALL be sampled synchronously, and the first start_i SHALL be accepted on the first clock after deassertion.

Structure
REQ-036 The state encoding enum and default parameter constants SHALL live in shared package mux_matrix_pkg.
REQ-037 The row/column stepping SHALL be a single sub-module, matrix_index_counter (enabled wrap counter pair with terminal flags), instantiated once.

Verification
REQ-038 Rows=Cols=2, SettleCycles=3, adc_done_i 2 clocks after each start -> indices (0,0),(0,1),(1,0),(1,1), exactly 4 adc_start_o pulses, and frame_done_o one clock after the 4th NEXT.
REQ-039 start_i pulsed mid-frame -> ignored, frame completes with exactly 4 conversions.
REQ-040 adc_done_i never asserted, TimeoutCycles=8 -> err_o=1 after 8 WAIT clocks, busy_o=0, no frame_done_o.
REQ-041 abort_i in WAIT of pixel (1,0) together with adc_done_i -> IDLE next clock, row=col=0, no frame_done_o.
REQ-042 rst_ni low for 1 clock during SETTLE of (0,1) -> immediate all-zero outputs, and new start_i scans from (0,0).
REQ-043 Rows=3, Cols=1, Width=5 -> col_o=0 throughout, row_o 0->1->2, 3 conversions.
